// File: rtl/bus_pkg.sv
// Shared bus constants: default geometry and channel-select encoding.
package bus_pkg;
  localparam int unsigned DEF_WIDTH = 8;
  localparam int unsigned DEF_DEPTH = 4;
  localparam logic CH0 = 1'b0;
  localparam logic CH1 = 1'b1;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered full/empty flags and occupancy count.
module sync_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     wr_en,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    count_q;
  logic [CW-1:0]    count_d;
  logic             do_wr;
  logic             do_rd;

  // Guards keep a full FIFO from overwriting and an empty one from underflowing.
  assign do_wr = wr_en && !full;
  assign do_rd = rd_en && !empty;

  always_comb begin
    count_d = count_q;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + AW'(1);
      if (do_rd) rd_ptr <= rd_ptr + AW'(1);
      count_q <= count_d;
      full    <= (count_d == CW'(DEPTH));
      empty   <= (count_d == '0);
    end
  end

  // Storage is not reset; stale contents are hidden by the empty flag.
  always_ff @(posedge clk) begin
    if (do_wr) mem[wr_ptr] <= wr_data;
  end

  assign rd_data = mem[rd_ptr];
  assign count   = count_q;
endmodule

// File: rtl/bus_demux8.sv
// Steers bus bytes to one of two channel FIFOs by the sel bit travelling with each byte.
module bus_demux8
  import bus_pkg::*;
#(
  parameter int unsigned DEPTH = DEF_DEPTH,
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   sel,
  input  logic [WIDTH-1:0]       bus1,
  input  logic                   bus_valid,
  output logic                   bus_ready,
  output logic [WIDTH-1:0]       data0,
  output logic [WIDTH-1:0]       data1,
  output logic                   data0_valid,
  output logic                   data1_valid,
  input  logic                   data0_ready,
  input  logic                   data1_ready,
  output logic [$clog2(DEPTH):0] count0,
  output logic [$clog2(DEPTH):0] count1
);
  logic             full0;
  logic             full1;
  logic             empty0;
  logic             empty1;
  logic             wr0;
  logic             wr1;
  logic [WIDTH-1:0] head0;
  logic [WIDTH-1:0] head1;

  // Ready reflects only the addressed channel, so a stalled consumer blocks only its own traffic.
  assign bus_ready = (sel == CH1) ? !full1 : !full0;
  assign wr0       = bus_valid && bus_ready && (sel == CH0);
  assign wr1       = bus_valid && bus_ready && (sel == CH1);

  assign data0_valid = !empty0;
  assign data1_valid = !empty1;
  assign data0       = empty0 ? '0 : head0;
  assign data1       = empty1 ? '0 : head1;

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo0 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr0),
    .wr_data (bus1),
    .rd_en   (data0_ready),
    .rd_data (head0),
    .full    (full0),
    .empty   (empty0),
    .count   (count0)
  );

  sync_fifo #(.DEPTH(DEPTH), .WIDTH(WIDTH)) u_fifo1 (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr1),
    .wr_data (bus1),
    .rd_en   (data1_ready),
    .rd_data (head1),
    .full    (full1),
    .empty   (empty1),
    .count   (count1)
  );
endmodule

// File: tb/tb_bus_demux8.sv
// Directed bench for bus_demux8 with a per-channel expected-byte queue model.
module tb_bus_demux8;
  localparam int unsigned DEPTH = 4;
  localparam int unsigned WIDTH = 8;
  localparam int unsigned CW    = $clog2(DEPTH) + 1;

  logic             clk = 1'b0;
  logic             rst;
  logic             sel;
  logic [WIDTH-1:0] bus1;
  logic             bus_valid;
  logic             bus_ready;
  logic [WIDTH-1:0] data0;
  logic [WIDTH-1:0] data1;
  logic             data0_valid;
  logic             data1_valid;
  logic             data0_ready;
  logic             data1_ready;
  logic [CW-1:0]    count0;
  logic [CW-1:0]    count1;

  int checks = 0;
  int errors = 0;
  int pops0  = 0;
  int pops1  = 0;
  logic [WIDTH-1:0] q0[$];
  logic [WIDTH-1:0] q1[$];

  always #5 clk = ~clk;

  bus_demux8 #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .sel         (sel),
    .bus1        (bus1),
    .bus_valid   (bus_valid),
    .bus_ready   (bus_ready),
    .data0       (data0),
    .data1       (data1),
    .data0_valid (data0_valid),
    .data1_valid (data1_valid),
    .data0_ready (data0_ready),
    .data1_ready (data1_ready),
    .count0      (count0),
    .count1      (count1)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Compare DUT against the queue model at the falling edge, then advance the model.
  task automatic check_cycle();
    logic             exp_rdy;
    logic [WIDTH-1:0] tmp;
    if (rst) begin
      q0.delete();
      q1.delete();
    end
    exp_rdy = sel ? (q1.size() < int'(DEPTH)) : (q0.size() < int'(DEPTH));
    chk("bus_ready",   16'(bus_ready),   16'(exp_rdy));
    chk("data0_valid", 16'(data0_valid), 16'(q0.size() != 0));
    chk("data1_valid", 16'(data1_valid), 16'(q1.size() != 0));
    chk("data0",       16'(data0),       (q0.size() != 0) ? 16'(q0[0]) : 16'h0);
    chk("data1",       16'(data1),       (q1.size() != 0) ? 16'(q1[0]) : 16'h0);
    chk("count0",      16'(count0),      16'(q0.size()));
    chk("count1",      16'(count1),      16'(q1.size()));
    if (!rst) begin
      if (data0_ready && q0.size() != 0) begin tmp = q0.pop_front(); pops0++; end
      if (data1_ready && q1.size() != 0) begin tmp = q1.pop_front(); pops1++; end
      if (bus_valid && exp_rdy) begin
        if (sel) q1.push_back(bus1);
        else     q0.push_back(bus1);
      end
    end
  endtask

  task automatic step();
    @(negedge clk);
    check_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; sel = 1'b0; bus1 = '0; bus_valid = 1'b0;
    data0_ready = 1'b0; data1_ready = 1'b0;

    // Reset values, including bus_ready high.
    step();
    step();
    rst = 1'b0;
    step();
    chk("reset_bus_ready", 16'(bus_ready), 16'h1);

    // Single byte to channel 1.
    sel = 1'b1; bus1 = 8'hA5; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    step();
    chk("single_data1", 16'(data1), 16'h00A5);
    chk("single_count0", 16'(count0), 16'h0);
    data1_ready = 1'b1;
    step();
    data1_ready = 1'b0;

    // Fill channel 0 with 01..04 while nobody drains.
    sel = 1'b0; bus_valid = 1'b1;
    for (int i = 1; i <= 4; i++) begin
      bus1 = 8'(i);
      step();
    end
    bus1 = 8'h05;
    step();
    chk("full_count0", 16'(count0), 16'h4);
    chk("full_ready_sel0", 16'(bus_ready), 16'h0);
    sel = 1'b1; bus1 = 8'h77;
    step();

    // Full channel with same-cycle pop: push refused now, accepted next cycle.
    sel = 1'b0; bus1 = 8'h05; data0_ready = 1'b1;
    step();
    chk("pop_full_count0", 16'(count0), 16'h3);
    chk("pop_full_data0", 16'(data0), 16'h02);
    step();
    bus_valid = 1'b0; data1_ready = 1'b1;
    for (int i = 0; i < 5; i++) step();
    chk("drained_count0", 16'(count0), 16'h0);
    chk("drained_pops0", 16'(pops0), 16'd5);

    // Alternating full-rate stream with both consumers ready; pointers wrap.
    pops0 = 0; pops1 = 0;
    bus_valid = 1'b1;
    for (int i = 0; i < 20; i++) begin
      sel  = i[0];
      bus1 = 8'(8'h10 + i);
      step();
      chk("stream_ready", 16'(bus_ready), 16'h1);
    end
    bus_valid = 1'b0;
    step();
    step();
    chk("stream_pops0", 16'(pops0), 16'd10);
    chk("stream_pops1", 16'(pops1), 16'd10);

    // Reset with both channels partly full.
    data0_ready = 1'b0; data1_ready = 1'b0; bus_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      sel  = i[0];
      bus1 = 8'(8'hC0 + i);
      step();
    end
    bus_valid = 1'b0;
    step();
    chk("pre_reset_count1", 16'(count1), 16'h2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    step();
    sel = 1'b0; bus1 = 8'h3C; bus_valid = 1'b1;
    step();
    bus_valid = 1'b0;
    step();
    chk("post_reset_data0", 16'(data0), 16'h003C);
    chk("post_reset_count0", 16'(count0), 16'h1);
    chk("post_reset_count1", 16'(count1), 16'h0);
    data0_ready = 1'b1;
    step();
    step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
